// File: rtl/condicionador_pkg.sv
// rtl/condicionador_pkg.sv - shared state codes and defaults for the button conditioner
package condicionador_pkg;

  // Codes 4-7 are never produced; the FSM treats them as ESPERA.
  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    ESTAVEL = 3'd1,
    DECIDE  = 3'd2,
    SOLTAR  = 3'd3
  } estado_t;

  localparam int N_BOTOES_PADRAO = 7;
  localparam int DEBOUNCE_PADRAO = 50000;

endpackage

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - two-flop synchronizer for asynchronous board inputs
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - debounces the push-buttons into one registered one-hot jogada per press
module condicionador_botoes
  import condicionador_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  input  logic                limpa,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_feita,
  output logic                erro_multiplo,
  output logic                tem_jogada,
  output logic [2:0]          db_estado
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BOTOES-1:0] s_b;
  logic [N_BOTOES-1:0] amostra;
  logic [CNT_W-1:0]    cnt;
  estado_t             estado;
  logic                um_quente;

  sincronizador_2ff #(
    .LARGURA(N_BOTOES)
  ) u_sincronizador (
    .clock(clock),
    .reset(reset),
    .d    (botoes),
    .q    (s_b)
  );

  assign um_quente  = (amostra != '0) && ((amostra & (amostra - N_BOTOES'(1))) == '0);
  assign tem_jogada = |s_b;
  assign db_estado  = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= ESPERA;
      cnt           <= '0;
      amostra       <= '0;
      jogada        <= '0;
      jogada_feita  <= 1'b0;
      erro_multiplo <= 1'b0;
    end else begin
      jogada_feita  <= 1'b0;
      erro_multiplo <= 1'b0;
      // An accept in DECIDE below overrides this clear in the same cycle.
      if (limpa) jogada <= '0;

      case (estado)
        ESPERA: begin
          if (habilita && (s_b != '0)) begin
            amostra <= s_b;
            cnt     <= CNT_W'(1);
            estado  <= ESTAVEL;
          end
        end
        ESTAVEL: begin
          if (!habilita || (s_b != amostra)) begin
            cnt    <= '0;
            estado <= ESPERA;
          end else if (cnt == CNT_FIM) begin
            estado <= DECIDE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DECIDE: begin
          if (um_quente) begin
            jogada       <= amostra;
            jogada_feita <= 1'b1;
          end else begin
            erro_multiplo <= 1'b1;
          end
          cnt    <= '0;
          estado <= SOLTAR;
        end
        SOLTAR: begin
          // habilita is not consulted, so a held button cannot re-trigger.
          if (s_b != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_FIM) begin
            cnt    <= '0;
            estado <= ESPERA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt    <= '0;
          estado <= ESPERA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - self-checking bench for condicionador_botoes
module tb_condicionador_botoes;

  localparam int N = 7;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] botoes;
  logic         habilita;
  logic         limpa;
  logic [N-1:0] jogada;
  logic         jogada_feita;
  logic         erro_multiplo;
  logic         tem_jogada;
  logic [2:0]   db_estado;

  int n_tests = 0;
  int n_fail  = 0;

  condicionador_botoes #(
    .N_BOTOES       (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes       (botoes),
    .habilita     (habilita),
    .limpa        (limpa),
    .jogada       (jogada),
    .jogada_feita (jogada_feita),
    .erro_multiplo(erro_multiplo),
    .tem_jogada   (tem_jogada),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0] b;
    logic         h;
    logic         l;
    logic         f;
    logic         e;
    logic [N-1:0] j;
    logic [2:0]   s;
  } vec_t;

  vec_t tab[$];

  function automatic void add(logic [N-1:0] b, logic h, logic l, logic f, logic e,
                              logic [N-1:0] j, logic [2:0] s);
    vec_t v;
    v = '{b, h, l, f, e, j, s};
    tab.push_back(v);
  endfunction

  function automatic logic [2:0] est_press(int i);
    if (i < 3) return 3'd0;
    if (i < 6) return 3'd1;
    if (i == 6) return 3'd2;
    return 3'd3;
  endfunction

  task automatic check(string nome, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nome, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input logic h);
    reset    = 1'b1;
    habilita = h;
    botoes   = '0;
    limpa    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run(input int n, input logic [N-1:0] b, output int nf, output int first);
    nf    = 0;
    first = -1;
    for (int c = 0; c < n; c++) begin
      if (jogada_feita === 1'b1) begin
        nf++;
        if (first < 0) first = c;
      end
      botoes = b;
      step();
    end
  endtask

  // Reference model: run lengths of a stable non-zero sample, a release window
  // of D zero cycles, and a two-cycle delay line standing in for the synchronizer.
  logic [N-1:0] mq[$];
  logic [N-1:0] mval, mjog;
  logic         mfeita, merro, mtem;
  logic [2:0]   mest;
  int           mrun, mzeros;
  bit           mblocked, mdecide;

  task automatic model_step(input logic [N-1:0] raw, input logic h, input logic l, input logic r);
    logic [N-1:0] sb;
    bit accepted;
    if (r) begin
      mq = '{7'd0, 7'd0};
      mrun = 0; mzeros = 0; mblocked = 0; mdecide = 0;
      mval = '0; mjog = '0; mfeita = 0; merro = 0;
    end else begin
      sb = mq[0];
      accepted = 0;
      mfeita = 0;
      merro = 0;
      if (mdecide) begin
        mdecide = 0;
        mblocked = 1;
        mzeros = 0;
        if ($countones(mval) == 1) begin
          mfeita = 1;
          mjog = mval;
          accepted = 1;
        end else begin
          merro = 1;
        end
      end else if (mblocked) begin
        if (sb != '0) mzeros = 0;
        else begin
          mzeros++;
          if (mzeros == D) begin
            mblocked = 0;
            mzeros = 0;
          end
        end
      end else if (mrun == 0) begin
        if (h && sb != '0) begin
          mrun = 1;
          mval = sb;
        end
      end else if (!h || sb != mval) begin
        mrun = 0;
      end else begin
        mrun++;
        if (mrun == D) begin
          mdecide = 1;
          mrun = 0;
        end
      end
      if (l && !accepted) mjog = '0;
      void'(mq.pop_front());
      mq.push_back(raw);
    end
    mtem = |mq[0];
    if (mdecide) mest = 3'd2;
    else if (mblocked) mest = 3'd3;
    else if (mrun > 0) mest = 3'd1;
    else mest = 3'd0;
  endtask

  initial begin
    int nf, first, tot;
    int hold, r;
    logic [N-1:0] cur, one;
    logic rs, hb, lm;

    reset = 1'b1;
    habilita = 1'b0;
    limpa = 1'b0;
    botoes = '0;
    @(negedge clock);

    // Clean press, release, multi-press, limpa alone and limpa racing an accept.
    for (int i = 0; i < 10; i++) add(7'h04, 1, 0, i == 7, 0, (i >= 7) ? 7'h04 : 7'h00, est_press(i));
    for (int i = 0; i < 7; i++)  add(7'h00, 1, 0, 0, 0, 7'h04, (i < 6) ? 3'd3 : 3'd0);
    for (int i = 0; i < 10; i++) add(7'b0010010, 1, 0, 0, i == 7, 7'h04, est_press(i));
    for (int i = 0; i < 7; i++)  add(7'h00, 1, 0, 0, 0, 7'h04, (i < 6) ? 3'd3 : 3'd0);
    for (int i = 0; i < 10; i++)
      add(7'h40, 1, (i == 2) || (i == 6), i == 7, 0,
          (i < 3) ? 7'h04 : (i < 7) ? 7'h00 : 7'h40, est_press(i));

    do_reset(1'b1);
    for (int i = 0; i < tab.size(); i++) begin
      check($sformatf("tab[%0d].jogada_feita", i), 32'(jogada_feita), 32'(tab[i].f));
      check($sformatf("tab[%0d].erro_multiplo", i), 32'(erro_multiplo), 32'(tab[i].e));
      check($sformatf("tab[%0d].jogada", i), 32'(jogada), 32'(tab[i].j));
      check($sformatf("tab[%0d].db_estado", i), 32'(db_estado), 32'(tab[i].s));
      check($sformatf("tab[%0d].tem_jogada", i), 32'(tem_jogada),
            (i >= 2) ? 32'(|tab[i-2].b) : 32'd0);
      botoes   = tab[i].b;
      habilita = tab[i].h;
      limpa    = tab[i].l;
      step();
    end
    limpa = 1'b0;

    // Bounce: 2-cycle pulses never survive the window.
    do_reset(1'b1);
    tot = 0;
    for (int k = 0; k < 5; k++) begin
      run(2, 7'h01, nf, first); tot += nf;
      run(2, 7'h00, nf, first); tot += nf;
    end
    check("bounce strobes while toggling", 32'(tot), 32'd0);
    run(15, 7'h01, nf, first);
    check("bounce strobe count", 32'(nf), 32'd1);
    check("bounce strobe cycle", 32'(first), 32'd7);

    // Hold, short release, re-press.
    do_reset(1'b1);
    run(100, 7'h08, nf, first);
    check("hold strobe count", 32'(nf), 32'd1);
    check("hold strobe cycle", 32'(first), 32'd7);
    run(2, 7'h00, nf, first);
    run(30, 7'h08, nf, first);
    check("re-press before release window", 32'(nf), 32'd0);
    run(8, 7'h00, nf, first);
    run(12, 7'h08, nf, first);
    check("re-press after release window", 32'(nf), 32'd1);
    check("re-press strobe cycle", 32'(first), 32'd7);
    check("re-press jogada", 32'(jogada), 32'h08);

    // habilita gating.
    do_reset(1'b0);
    run(20, 7'h20, nf, first);
    check("habilita low strobes", 32'(nf), 32'd0);
    check("habilita low estado", 32'(db_estado), 32'd0);
    habilita = 1'b1;
    run(10, 7'h20, nf, first);
    check("habilita rise strobe count", 32'(nf), 32'd1);
    check("habilita rise strobe cycle", 32'(first), 32'd5);

    // Reset in ESTAVEL with cnt=2.
    do_reset(1'b1);
    run(20, 7'h02, nf, first);
    run(8, 7'h00, nf, first);
    check("pre-reset idle estado", 32'(db_estado), 32'd0);
    run(4, 7'h04, nf, first);
    check("pre-reset estado ESTAVEL", 32'(db_estado), 32'd1);
    check("pre-reset jogada", 32'(jogada), 32'h02);
    reset = 1'b1;
    step();
    check("post-reset estado", 32'(db_estado), 32'd0);
    check("post-reset jogada", 32'(jogada), 32'd0);
    check("post-reset strobe", 32'({jogada_feita, erro_multiplo}), 32'd0);
    reset = 1'b0;
    botoes = '0;
    run(3, 7'h00, nf, first);
    check("strobes after reset", 32'(nf), 32'd0);

    // Randomized run against the reference model.
    one = 7'd1;
    hold = 0;
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0)
        check($sformatf("random cycle %0d {jogada,feita,erro,tem,estado}", c),
              32'({jogada, jogada_feita, erro_multiplo, tem_jogada, db_estado}),
              32'({mjog, mfeita, merro, mtem, mest}));
      if (hold == 0) begin
        hold = $urandom_range(1, 10);
        r = $urandom_range(0, 9);
        if (r < 3) cur = '0;
        else if (r < 8) cur = one << $urandom_range(0, 6);
        else cur = 7'($urandom);
      end
      hold--;
      rs = (c == 0) || ($urandom_range(0, 199) == 0);
      hb = ($urandom_range(0, 9) != 0);
      lm = ($urandom_range(0, 19) == 0);
      reset = rs;
      habilita = hb;
      limpa = lm;
      botoes = cur;
      model_step(cur, hb, lm, rs);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
